// File: rtl/cp0_regs.sv
// cp0_regs: coprocessor-0 SR/Cause/EPC/PRId block with hardware interrupt sampling
module cp0_regs #(
  parameter logic [31:0] PRID     = 32'h0000_4C00,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [5:0]  hwint,
  input  logic        exl_set,
  input  logic [4:0]  exccode,
  input  logic [31:0] epc_in,
  input  logic        exl_clr,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        intreq
);
  logic [31:0] sr;
  logic [31:0] epc_r;
  logic [5:0]  ip;
  logic [4:0]  exc;
  logic [31:0] cause;
  logic        wr_sr, wr_cause, wr_epc;
  assign wr_sr    = we && sel == 5'd12;
  assign wr_cause = we && sel == 5'd13;
  assign wr_epc   = we && sel == 5'd14;
  assign cause    = {16'h0, ip, 3'b000, exc, 2'b00};
  assign epc      = epc_r;
  // exception entry beats mtc0 and eret; eret clears EXL after any SR write in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr    <= SR_RESET;
      epc_r <= 32'h0;
      ip    <= 6'h0;
      exc   <= 5'h0;
    end else begin
      ip <= hwint;
      if (exl_set) begin
        sr[1] <= 1'b1;
        exc   <= exccode;
        epc_r <= {epc_in[31:2], 2'b00};
      end else begin
        if (wr_sr) sr <= exl_clr ? {din[31:2], 1'b0, din[0]} : din;
        else if (exl_clr) sr[1] <= 1'b0;
        if (wr_cause) exc <= din[6:2];
        if (wr_epc) epc_r <= {din[31:2], 2'b00};
      end
    end
  end
  // read mux and interrupt request from registered state only
  always_comb begin
    dout = sel == 5'd12 ? sr :
           sel == 5'd13 ? cause :
           sel == 5'd14 ? epc_r :
           sel == 5'd15 ? PRID : 32'h0;
    intreq = |(ip & sr[15:10]) & sr[0] & ~sr[1];
  end
endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: randomized and directed checks of cp0_regs against a behavioural model
module tb_cp0_regs;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [4:0]  sel = 0;
  logic [31:0] din = 0;
  logic        we = 0;
  logic [5:0]  hwint = 0;
  logic        exl_set = 0;
  logic [4:0]  exccode = 0;
  logic [31:0] epc_in = 0;
  logic        exl_clr = 0;
  logic [31:0] dout, epc;
  logic        intreq;
  int total = 0;
  int bad = 0;
  logic [31:0] m_sr, m_epc;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;

  cp0_regs dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .din(din), .we(we), .hwint(hwint),
    .exl_set(exl_set), .exccode(exccode), .epc_in(epc_in), .exl_clr(exl_clr),
    .dout(dout), .epc(epc), .intreq(intreq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_dout(input logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return {16'h0, m_ip, 3'b000, m_exc, 2'b00};
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4C00;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_int();
    return (m_ip & m_sr[15:10]) != 6'h0 && m_sr[0] && !m_sr[1];
  endfunction

  task automatic step();
    logic [31:0] n_sr;
    @(posedge clk);
    if (!rst_n) begin
      m_sr = 32'h0; m_epc = 32'h0; m_ip = 6'h0; m_exc = 5'h0;
    end else begin
      n_sr = m_sr;
      if (exl_set) begin
        n_sr[1] = 1'b1;
        m_exc = exccode;
        m_epc = epc_in & 32'hFFFF_FFFC;
      end else begin
        if (we && sel == 5'd12) n_sr = din;
        if (exl_clr) n_sr[1] = 1'b0;
        if (we && sel == 5'd13) m_exc = din[6:2];
        if (we && sel == 5'd14) m_epc = din & 32'hFFFF_FFFC;
      end
      m_sr = n_sr;
      m_ip = hwint;
    end
    #1;
  endtask

  task automatic idle();
    we = 0; exl_set = 0; exl_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; we = 1; din = 32'hFFFF_FFFF; sel = 5'd12;
    step(); step();
    rst_n = 1; idle(); #1;
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_sr got=%h want=%h", dout, 32'h0); end
    total++; if (intreq !== 1'b0) begin bad++; $display("FAIL reset_intreq got=%b want=0", intreq); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h want=0", epc); end
    sel = 5'd15; #1;
    total++; if (dout !== 32'h0000_4C00) begin bad++; $display("FAIL prid got=%h want=00004c00", dout); end
    sel = 5'd7; #1;
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL sel7 got=%h want=0", dout); end
  endtask

  task automatic test_interrupt();
    we = 1; sel = 5'd12; din = 32'h0000_0401;
    step(); idle();
    hwint = 6'b000001; #1;
    total++; if (intreq !== 1'b0) begin bad++; $display("FAIL int_same_cycle got=%b want=0", intreq); end
    step();
    total++; if (intreq !== 1'b1) begin bad++; $display("FAIL int_next_cycle got=%b want=1", intreq); end
    hwint = 6'b000010; step();
    total++; if (intreq !== 1'b0) begin bad++; $display("FAIL int_masked got=%b want=0", intreq); end
    hwint = 6'b000001; step();
    total++; if (intreq !== exp_int()) begin bad++; $display("FAIL int_restore got=%b want=%b", intreq, exp_int()); end
  endtask

  task automatic test_exception();
    exl_set = 1; exccode = 5'd0; epc_in = 32'h0040_0107;
    step(); idle();
    sel = 5'd13; #1;
    total++; if (epc !== 32'h0040_0104) begin bad++; $display("FAIL exc_epc got=%h want=00400104", epc); end
    total++; if (intreq !== 1'b0) begin bad++; $display("FAIL exc_intreq got=%b want=0", intreq); end
    total++; if (dout[15:10] !== 6'b000001 || dout[6:2] !== 5'd0) begin bad++; $display("FAIL exc_cause got=%h want ip=01 code=0", dout); end
    sel = 5'd12; #1;
    total++; if (dout !== 32'h0000_0403) begin bad++; $display("FAIL exc_sr got=%h want=00000403", dout); end
  endtask

  task automatic test_eret();
    exl_clr = 1; step(); idle();
    sel = 5'd12; #1;
    total++; if (dout[1] !== 1'b0) begin bad++; $display("FAIL eret_exl got=%b want=0", dout[1]); end
    total++; if (intreq !== 1'b1) begin bad++; $display("FAIL eret_intreq got=%b want=1", intreq); end
    total++; if (epc !== 32'h0040_0104) begin bad++; $display("FAIL eret_epc got=%h want=00400104", epc); end
  endtask

  task automatic test_collisions();
    logic [31:0] pc;
    exl_set = 1; exl_clr = 1; exccode = 5'd8; epc_in = 32'h0000_1000;
    step(); idle(); sel = 5'd12; #1;
    total++; if (dout[1] !== 1'b1) begin bad++; $display("FAIL set_clr_exl got=%b want=1", dout[1]); end
    pc = $urandom;
    exl_set = 1; we = 1; sel = 5'd14; din = 32'h1234_5678; epc_in = pc;
    step(); idle(); #1;
    total++; if (epc !== {pc[31:2], 2'b00}) begin bad++; $display("FAIL set_we_epc got=%h want=%h", epc, {pc[31:2], 2'b00}); end
    we = 1; sel = 5'd12; din = 32'h0000_0003; exl_clr = 1;
    step(); idle(); #1;
    total++; if (dout !== 32'h0000_0001) begin bad++; $display("FAIL we_clr_sr got=%h want=00000001", dout); end
  endtask

  task automatic test_rdw();
    logic [31:0] old;
    old = m_epc;
    we = 1; sel = 5'd14; din = 32'hABCD_EF03; #1;
    total++; if (dout !== old) begin bad++; $display("FAIL rdw_old got=%h want=%h", dout, old); end
    step(); idle(); #1;
    total++; if (dout !== 32'hABCD_EF00) begin bad++; $display("FAIL rdw_new got=%h want=abcdef00", dout); end
    we = 1; sel = 5'd13; din = 32'hFFFF_FFFF; hwint = 6'b101010;
    step(); idle(); #1;
    total++; if (dout !== {16'h0, 6'b101010, 3'b000, 5'b11111, 2'b00}) begin bad++; $display("FAIL cause_mask got=%h want=%h", dout, {16'h0, 6'b101010, 3'b000, 5'b11111, 2'b00}); end
    hwint = 6'b010101; step(); #1;
    total++; if (dout !== {16'h0, 6'b010101, 3'b000, 5'b11111, 2'b00}) begin bad++; $display("FAIL cause_track got=%h want=%h", dout, {16'h0, 6'b010101, 3'b000, 5'b11111, 2'b00}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n   = $urandom_range(0, 59) != 0;
      we      = $urandom_range(0, 1);
      sel     = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(11, 16));
      din     = $urandom;
      exl_set = $urandom_range(0, 7) == 0;
      exl_clr = $urandom_range(0, 3) == 0;
      exccode = 5'($urandom);
      epc_in  = $urandom;
      if ($urandom_range(0, 2) == 0) hwint = 6'($urandom);
      #1;
      total++; if (dout !== exp_dout(sel)) begin bad++; $display("FAIL rnd_dout i=%0d sel=%0d got=%h want=%h", i, sel, dout, exp_dout(sel)); end
      total++; if (intreq !== exp_int()) begin bad++; $display("FAIL rnd_intreq i=%0d got=%b want=%b", i, intreq, exp_int()); end
      total++; if (epc !== m_epc) begin bad++; $display("FAIL rnd_epc i=%0d got=%h want=%h", i, epc, m_epc); end
      step();
    end
    rst_n = 1; idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_interrupt();
    test_exception();
    test_eret();
    test_collisions();
    test_rdw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register block for the multi-cycle MIPS core.
- Holds SR, Cause, EPC and PRId.
- Samples the external hardware interrupt lines and raises an interrupt request to the controller.
- Services mtc0 writes, exception entry and eret.
- Its read port is the cp0 data source selected by the write-back mux (wdsel = 3'b100) for mfc0.

Parameters:
- PRID, 32'h0000_4C00, read-only processor ID returned at register 15.
- SR_RESET, 32'h0000_0000, SR value loaded on reset (interrupts disabled).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- sel  input  5  CP0 register number (instruction rd field) for read and mtc0 write.
- din  input  32  mtc0 write data (GPR rt value).
- we  input  1  mtc0 write strobe, one cycle.
- hwint  input  6  external hardware interrupt lines, level-sensitive.
- exl_set  input  1  exception entry strobe from the controller, one cycle.
- exccode  input  5  exception code latched on exl_set (0 = interrupt, 8 = syscall).
- epc_in  input  32  PC to save into EPC on exl_set.
- exl_clr  input  1  eret strobe, one cycle.
- dout  output  32  combinational read data for sel (feeds cp0out of the write-back mux).
- epc  output  32  current EPC register, used by the PC mux on eret.
- intreq  output  1  interrupt request to the controller.

Behaviour:
- Reset (rst_n low at a clock edge): SR <= SR_RESET, Cause <= 0, EPC <= 0, hwint sample register <= 0.
  - dout follows its read rule from these values; intreq = 0.
- SR fields:
  - IM = SR[15:10], EXL = SR[1], IE = SR[0].
  - All other bits are stored as written but have no function.
- Cause fields:
  - IP = Cause[15:10], ExcCode = Cause[6:2].
  - All other bits read 0 and are not writable.
- IP sampling:
  - Every non-reset cycle, Cause.IP <= hwint.
  - One-cycle latency from an hwint change to IP.
  - mtc0 cannot write IP.
- intreq (combinational from registered state only) = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
  - An hwint edge therefore reaches intreq exactly one clock later.
  - A level held low by the source clears intreq one clock after it drops.
- Read port (combinational):
  - sel 12 -> SR; 13 -> Cause; 14 -> EPC; 15 -> PRID; any other -> 32'h0.
  - Read during a write returns the old value; the new value is visible the cycle after the edge.
- mtc0 (we = 1, exl_set = 0):
  - sel 12: SR <= din.
  - sel 13: ExcCode <= din[6:2].
  - sel 14: EPC <= {din[31:2], 2'b00}.
  - sel 15 or any other sel: no state change.
- Exception entry (exl_set = 1):
  - SR.EXL <= 1.
  - Cause.ExcCode <= exccode.
  - EPC <= {epc_in[31:2], 2'b00}.
  - Other SR bits are unchanged.
  - IP sampling continues regardless.
- eret (exl_clr = 1, exl_set = 0): SR.EXL <= 0; all other state is unchanged.
- Simultaneous events, by priority:
  - exl_set wins over exl_clr: EXL ends at 1.
  - exl_set wins over we for SR, Cause and EPC: the mtc0 is dropped. The controller aborts that instruction and must reissue it after eret.
  - we to sel 12 together with exl_clr: SR <= din, then EXL forced to 0.
  - we to sel 14 together with exl_clr: EPC takes din.
- Nested protection: while EXL = 1, intreq stays 0 regardless of IP, IM and IE.
- Reset mid-operation: reset overrides every strobe in the same cycle; all state returns to reset values.

Test Plan:
- Reset and ID read:
  - Stimulus: hold rst_n low 2 cycles with we = 1, din = FFFF_FFFF, sel = 12; then release.
  - Required: SR = 0, intreq = 0; sel 15 -> dout = 0000_4C00; sel 7 -> dout = 0.
- Interrupt path:
  - Stimulus: mtc0 sel 12 din = 0000_0401 (IM[0] = 1, IE = 1); then raise hwint = 6'b000001.
  - Required: intreq is 0 on that cycle and 1 on the next; hwint = 6'b000010 alone keeps intreq = 0.
- Exception entry:
  - Stimulus: with intreq = 1, pulse exl_set, exccode = 0, epc_in = 0040_0107.
  - Required:
    - next cycle EPC = 0040_0104, SR.EXL = 1, intreq = 0;
    - sel 13 -> dout[15:10] = 000001, dout[6:2] = 0;
    - sel 12 -> dout = 0000_0403.
- eret:
  - Stimulus: with hwint still 1, pulse exl_clr.
  - Required: EXL = 0; intreq = 1 the following cycle; EPC unchanged at 0040_0104.
- Priority and collisions:
  - exl_set + exl_clr in the same cycle -> EXL = 1.
  - exl_set + we sel 14 din = 1234_5678 in the same cycle -> EPC = epc_in, not 1234_5678.
  - we sel 12 din = 0000_0003 + exl_clr -> SR = 0000_0001.
- Read-during-write and masked writes:
  - mtc0 sel 14 din = ABCD_EF03: dout on the same cycle shows the old EPC; the next cycle shows ABCD_EF00.
  - mtc0 sel 13 din = FFFF_FFFF: Cause becomes {IP, 0, ExcCode = 11111, 00}; IP keeps tracking hwint.
